// File: rtl/uart_fifo_if.sv
// uart_fifo_if: 32-bit peripheral bus between the CPU and the UART.
//   data_in  host -> UART write data
//   addr     host -> UART word register index
//   cs       host -> UART block select
//   oe       host -> UART read strobe
//   wstrb    host -> UART byte write enables
//   data_out UART -> host combinational read data (0 unless cs && oe)
interface uart_fifo_if;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [5:0]  addr;
  logic        cs;
  logic        oe;
  logic [3:0]  wstrb;

  modport master (output data_in, addr, cs, oe, wstrb, input data_out);
  modport slave  (input data_in, addr, cs, oe, wstrb, output data_out);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex 8-bit UART with TX/RX FIFOs, optional parity,
// 1/2 stop bits, per-byte error flags, sticky overflow flags, level irq.
//   clk, rst  clock, asynchronous active-high reset
//   bus       peripheral bus (slave side): DATA 0x00, STATUS 0x01,
//             CTRL 0x02, BRR 0x03
//   rxd       asynchronous serial input
//   txd       serial output, idle high
//   irq       registered level interrupt
module uart_fifo #(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int BRR_WIDTH = 16,
  parameter int RESET_BRR = 0
) (
  input  logic       clk,
  input  logic       rst,
  uart_fifo_if.slave bus,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0]           TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]           RX_FULL_CNT = (RAW+1)'(RX_DEPTH);
  localparam logic [BRR_WIDTH-1:0]   BRR_RST     = BRR_WIDTH'(RESET_BRR);
  localparam logic [BRR_WIDTH-1:0]   BRR_ONE     = BRR_WIDTH'(1);
  localparam logic [TAW:0]           TP_ONE      = (TAW+1)'(1);
  localparam logic [RAW:0]           RP_ONE      = (RAW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // control / status
  logic [7:0]           ctrl_q, ctrl_d;
  logic [BRR_WIDTH-1:0] brr_q, brr_d;
  logic                 rxovf_q, rxovf_d, txovf_q, txovf_d, irq_q, irq_d;

  // FIFOs: pointers carry one extra wrap bit so full and empty differ
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [9:0]     rx_mem [RX_DEPTH];
  logic [TAW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt;
  logic [RAW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
  logic           tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic           tx_push, tx_pop, rx_push, rx_push_req, rx_pop;
  logic [7:0]     tx_head;
  logic [9:0]     rx_head, rx_wdata;

  // transmitter
  state_t               tx_st_q, tx_st_d;
  logic [BRR_WIDTH-1:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_load;

  // receiver; rx_sync_q[1:0] is the synchroniser, [2] the previous sample
  logic [2:0]           rx_sync_q, rx_sync_d;
  state_t               rx_st_q, rx_st_d;
  logic [BRR_WIDTH-1:0] rx_tmr_q, rx_tmr_d, rx_half_ld;
  logic [BRR_WIDTH:0]   brr_p1;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic                 rx_pe_q, rx_pe_d, rx_s, rx_fall;

  logic wr_data, rd_data, par_en, odd, two_stop, rx_en, tx_en;
  logic [31:0] rdata;
  logic unused_bits;

  assign par_en   = ctrl_q[0] ^ ctrl_q[1];
  assign odd      = ctrl_q[1];
  assign two_stop = ctrl_q[2];
  assign rx_en    = ctrl_q[3];
  assign tx_en    = ctrl_q[4];

  assign wr_data = bus.cs && bus.addr == 6'd0 && bus.wstrb[0];
  assign rd_data = bus.cs && bus.oe && bus.addr == 6'd0;

  assign tx_cnt   = tx_wr_q - tx_rd_q;
  assign rx_cnt   = rx_wr_q - rx_rd_q;
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == TX_FULL_CNT;
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == RX_FULL_CNT;
  assign tx_idle  = tx_empty && tx_st_q == S_IDLE;
  assign tx_head  = tx_mem[tx_rd_q[TAW-1:0]];
  assign rx_head  = rx_mem[rx_rd_q[RAW-1:0]];

  // a push into a full FIFO is still accepted when the same edge pops
  assign tx_push = wr_data && (!tx_full || tx_pop);
  assign rx_pop  = rd_data && !rx_empty;
  assign rx_push = rx_push_req && (!rx_full || rx_pop);

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] && !rx_sync_q[1];
  assign brr_p1  = {1'b0, brr_q} + {{BRR_WIDTH{1'b0}}, 1'b1};
  // timer is checked at zero, so load half-1 to land on the start centre
  assign rx_half_ld = (brr_p1[BRR_WIDTH:1] == '0) ? '0 : brr_p1[BRR_WIDTH:1] - BRR_ONE;

  assign unused_bits = ^{bus.data_in[31:24], bus.wstrb[3], brr_p1[0]};

  // ---------------- transmitter ----------------
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tmr_d = tx_tmr_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    txd_d    = txd_q;
    tx_load  = 1'b0;
    if (tx_st_q != S_IDLE)
      tx_tmr_d = (tx_tmr_q == '0) ? brr_q : tx_tmr_q - BRR_ONE;
    case (tx_st_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_en && !tx_empty) tx_load = 1'b1;
      end
      S_START: if (tx_tmr_q == '0) begin
        tx_st_d  = S_DATA;
        txd_d    = tx_sh_q[0];
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = 3'd0;
      end
      S_DATA: if (tx_tmr_q == '0) begin
        if (tx_bit_q == 3'd7) begin
          tx_bit_d = 3'd0;
          tx_st_d  = par_en ? S_PAR : S_STOP;
          txd_d    = par_en ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
        end
      end
      S_PAR: if (tx_tmr_q == '0) begin
        tx_st_d = S_STOP;
        txd_d   = 1'b1;
      end
      S_STOP: if (tx_tmr_q == '0) begin
        if (two_stop && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
        else if (tx_en && !tx_empty)      tx_load  = 1'b1;  // no idle gap
        else                              tx_st_d  = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_st_d  = S_START;
      txd_d    = 1'b0;
      tx_tmr_d = brr_q;
      tx_bit_d = 3'd0;
      tx_sh_d  = tx_head;
      tx_par_d = ^tx_head ^ odd;
    end
  end
  assign tx_pop = tx_load;

  // ---------------- receiver ----------------
  always_comb begin
    rx_sync_d   = {rx_sync_q[1:0], rxd};
    rx_st_d     = rx_st_q;
    rx_tmr_d    = rx_tmr_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_pe_d     = rx_pe_q;
    rx_push_req = 1'b0;
    if (rx_st_q != S_IDLE)
      rx_tmr_d = (rx_tmr_q == '0) ? brr_q : rx_tmr_q - BRR_ONE;
    case (rx_st_q)
      S_IDLE: if (rx_fall) begin
        rx_st_d  = S_START;
        rx_tmr_d = rx_half_ld;
      end
      S_START: if (rx_tmr_q == '0) begin
        rx_st_d  = rx_s ? S_IDLE : S_DATA;  // high at centre: false start
        rx_bit_d = 3'd0;
      end
      S_DATA: if (rx_tmr_q == '0) begin
        rx_sh_d = {rx_s, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) begin
          rx_st_d = par_en ? S_PAR : S_STOP;
          rx_pe_d = 1'b0;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      S_PAR: if (rx_tmr_q == '0) begin
        rx_pe_d = rx_s ^ (^rx_sh_q) ^ odd;
        rx_st_d = S_STOP;
      end
      S_STOP: if (rx_tmr_q == '0) begin
        rx_push_req = 1'b1;
        rx_st_d     = S_IDLE;
      end
      default: rx_st_d = S_IDLE;
    endcase
    if (!rx_en) begin
      rx_st_d     = S_IDLE;
      rx_push_req = 1'b0;
    end
  end
  // after a framing error the line is low, so rx_fall only re-arms on high
  assign rx_wdata = {!rx_s, rx_pe_q, rx_sh_q};

  // ---------------- registers and FIFO pointers ----------------
  always_comb begin
    ctrl_d  = ctrl_q;
    brr_d   = brr_q;
    rxovf_d = rxovf_q;
    txovf_d = txovf_q;
    tx_wr_d = tx_wr_q + (tx_push ? TP_ONE : '0);
    tx_rd_d = tx_rd_q + (tx_pop  ? TP_ONE : '0);
    rx_wr_d = rx_wr_q + (rx_push ? RP_ONE : '0);
    rx_rd_d = rx_rd_q + (rx_pop  ? RP_ONE : '0);
    if (bus.cs && bus.addr == 6'd1 && bus.wstrb[0]) begin
      if (bus.data_in[5]) rxovf_d = 1'b0;
      if (bus.data_in[6]) txovf_d = 1'b0;
    end
    // overflow setting wins over a same-cycle clear
    if (wr_data && !tx_push)     txovf_d = 1'b1;
    if (rx_push_req && !rx_push) rxovf_d = 1'b1;
    if (bus.cs && bus.addr == 6'd2 && bus.wstrb[0]) ctrl_d = bus.data_in[7:0];
    if (bus.cs && bus.addr == 6'd3)
      for (int i = 0; i < BRR_WIDTH; i++)
        if (bus.wstrb[i/8]) brr_d[i] = bus.data_in[i];
    irq_d = (ctrl_q[5] & !rx_empty) | (ctrl_q[6] & tx_empty) |
            (ctrl_q[7] & (rxovf_q | txovf_q));
  end

  always_comb begin
    rdata = '0;
    if (bus.cs && bus.oe)
      case (bus.addr)
        6'd0:    rdata = rx_empty ? '0 : {22'b0, rx_head};
        6'd1:    rdata = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, txovf_q, rxovf_q,
                          tx_idle, tx_full, tx_empty, rx_full, !rx_empty};
        6'd2:    rdata = {24'b0, ctrl_q};
        6'd3:    rdata = 32'(brr_q);
        default: rdata = '0;
      endcase
  end
  assign bus.data_out = rdata;
  assign txd = txd_q;
  assign irq = irq_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= bus.data_in[7:0];
    if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= rx_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= 8'h18;
      brr_q     <= BRR_RST;
      rxovf_q   <= 1'b0;
      txovf_q   <= 1'b0;
      irq_q     <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      tx_st_q   <= S_IDLE;
      tx_tmr_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      txd_q     <= 1'b1;
      rx_sync_q <= '1;
      rx_st_q   <= S_IDLE;
      rx_tmr_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_pe_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      brr_q     <= brr_d;
      rxovf_q   <= rxovf_d;
      txovf_q   <= txovf_d;
      irq_q     <= irq_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      tx_st_q   <= tx_st_d;
      tx_tmr_q  <= tx_tmr_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      txd_q     <= txd_d;
      rx_sync_q <= rx_sync_d;
      rx_st_q   <= rx_st_d;
      rx_tmr_q  <= rx_tmr_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_pe_q   <= rx_pe_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo (BRR=3, 16-deep FIFOs).
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic rxd, txd, irq;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] d;
  logic [63:0] pat;
  int          st;
  logic        idl_in, idl_end;

  uart_fifo_if bus ();
  assign rxd = loop ? txd : rxd_drv;

  uart_fifo #(.TX_DEPTH(16), .RX_DEPTH(16), .BRR_WIDTH(16), .RESET_BRR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rxd(rxd), .txd(txd), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // all bus tasks start and end 1 time unit after a rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] v, input logic [3:0] s);
    bus.cs = 1'b1; bus.oe = 1'b0; bus.addr = a; bus.data_in = v; bus.wstrb = s;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = a; bus.wstrb = 4'h0;
    @(negedge clk); v = bus.data_out;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.oe = 1'b0;
  endtask

  task automatic rx_bit(input logic b);
    rxd_drv = b;
    cyc(4);
  endtask

  // samples txd and STATUS.tx_idle for 60 clocks; pat holds the frame with
  // the first (start) clock in the MSB, st is the first low sample index
  task automatic tx_cap(input int len, output logic [63:0] p, output int s,
                        output logic i_in, output logic i_end);
    logic t [60];
    logic id [60];
    bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = 6'd1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      t[k] = txd;
      id[k] = bus.data_out[4];
    end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.oe = 1'b0;
    s = -1; p = '0; i_in = 1'bx; i_end = 1'bx;
    for (int k = 59; k >= 0; k--) if (t[k] === 1'b0) s = k;
    if (s >= 0 && s + len < 60) begin
      for (int i = 0; i < len; i++) p[len-1-i] = t[s+i];
      i_in  = id[s+len-1];
      i_end = id[s+len];
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.oe = 1'b0; bus.addr = '0; bus.data_in = '0; bus.wstrb = '0;
    cyc(2);
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    cyc(1);
    rd(6'd1, d); chk("rst_status", d, 32'h14);
    rd(6'd2, d); chk("rst_ctrl", d, 32'h18);
    rd(6'd3, d); chk("rst_brr", d, 32'h0);
    rd(6'd0, d); chk("rst_data_empty", d, 32'h0);

    // TX 0xA5, 8N1, BRR=3
    wr(6'd3, 32'h3, 4'b0111);
    rd(6'd3, d); chk("brr_wr", d, 32'h3);
    wr(6'd0, 32'hA5, 4'b0001);
    tx_cap(40, pat, st, idl_in, idl_end);
    chk("tx_a5_latency", 64'(st), 64'd1);
    chk("tx_a5_frame", pat, 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111);
    chk("tx_a5_busy_in_stop", idl_in, 1'b0);
    chk("tx_a5_idle_after", idl_end, 1'b1);

    // even parity, 0x03 -> parity 0
    wr(6'd2, 32'h19, 4'b0001);
    wr(6'd0, 32'h03, 4'b0001);
    tx_cap(44, pat, st, idl_in, idl_end);
    chk("tx_even_frame", pat,
        44'b0000_1111_1111_0000_0000_0000_0000_0000_0000_0000_1111);
    chk("tx_even_idle_after", idl_end, 1'b1);

    // odd parity, 0x03 -> parity 1
    wr(6'd2, 32'h1A, 4'b0001);
    wr(6'd0, 32'h03, 4'b0001);
    tx_cap(44, pat, st, idl_in, idl_end);
    chk("tx_odd_frame", pat,
        44'b0000_1111_1111_0000_0000_0000_0000_0000_0000_1111_1111);
    chk("tx_odd_busy_in_stop", idl_in, 1'b0);

    // loopback: 17 bytes into a 16-deep RX FIFO
    wr(6'd2, 32'h18, 4'b0001);
    loop = 1'b1;
    for (int i = 0; i <= 16; i++) wr(6'd0, 32'(i), 4'b0001);
    cyc(760);
    rd(6'd1, d); chk("rx_full_status", d, 32'h0000_1037);
    wr(6'd2, 32'h98, 4'b0001);
    cyc(2);
    chk("irq_err", irq, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd(6'd0, d);
      chk("rx_loop_data", d, 64'(i));
    end
    rd(6'd1, d); chk("rx_drained_status", d, 32'h34);
    wr(6'd1, 32'h20, 4'b0001);
    cyc(2);
    chk("irq_err_cleared", irq, 1'b0);
    rd(6'd1, d); chk("rxovf_w1c", d, 32'h14);
    wr(6'd2, 32'h18, 4'b0001);
    loop = 1'b0;

    // framing error: 0x55 with stop low, line held low afterwards
    wr(6'd2, 32'h38, 4'b0001);
    rx_bit(1'b0);
    rx_bit(1'b1); rx_bit(1'b0); rx_bit(1'b1); rx_bit(1'b0);
    rx_bit(1'b1); rx_bit(1'b0); rx_bit(1'b1); rx_bit(1'b0);
    rx_bit(1'b0);
    cyc(40);
    rd(6'd1, d); chk("rx_fe_one_entry", d, 32'h115);
    chk("irq_rx", irq, 1'b1);
    rd(6'd0, d); chk("rx_fe_data", d, 32'h255);
    cyc(2);
    chk("irq_rx_cleared", irq, 1'b0);
    rxd_drv = 1'b1;
    cyc(20);
    rd(6'd1, d); chk("rx_fe_no_more", d, 32'h14);

    // 1-clock glitch on idle line
    rxd_drv = 1'b0;
    cyc(1);
    rxd_drv = 1'b1;
    cyc(20);
    rd(6'd1, d); chk("rx_glitch_status", d, 32'h14);
    rd(6'd0, d); chk("rx_glitch_data", d, 32'h0);
    wr(6'd2, 32'h18, 4'b0001);

    // reset during the second of 8 frames
    wr(6'd2, 32'h58, 4'b0001);
    cyc(2);
    chk("irq_tx_empty", irq, 1'b1);
    for (int i = 0; i < 8; i++) wr(6'd0, 32'h00, 4'b0001);
    cyc(40);
    rd(6'd1, d); chk("tx_count_frame2", 64'(d[23:16]), 64'd6);
    @(negedge clk);
    chk("tx_frame2_low", txd, 1'b0);
    chk("irq_tx_busy", irq, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_txd", txd, 1'b1);
    chk("rst_async_irq", irq, 1'b0);
    bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = 6'd1;
    #1;
    chk("rst_async_txcount", 64'(bus.data_out[23:16]), 64'd0);
    bus.cs = 1'b0; bus.oe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);
    rd(6'd1, d); chk("post_rst_status", d, 32'h14);
    rd(6'd2, d); chk("post_rst_ctrl", d, 32'h18);
    chk("post_rst_txd", txd, 1'b1);
    chk("post_rst_irq", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
